// File: rtl/btn_event_io_pkg.sv
// Shared register map and helpers for the button event peripheral.
// The offsets here are the ones software uses inside the peripheral window.
package btn_event_io_pkg;

    localparam logic [31:0] BTN_BASE_ADDR = 32'h0000_3000;

    localparam logic [11:0] BTN_STATE   = 12'h000;
    localparam logic [11:0] BTN_PRESS   = 12'h004;
    localparam logic [11:0] BTN_RELEASE = 12'h008;
    localparam logic [11:0] BTN_CTRL    = 12'h00C;
    localparam logic [11:0] BTN_COUNT   = 12'h010;

    typedef enum logic [2:0] {
        REG_STATE   = BTN_STATE[4:2],
        REG_PRESS   = BTN_PRESS[4:2],
        REG_RELEASE = BTN_RELEASE[4:2],
        REG_CTRL    = BTN_CTRL[4:2],
        REG_COUNT   = BTN_COUNT[4:2]
    } regSel_e;

    function automatic logic [4:0] popCount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_event_io_if.sv
// Peripheral-port bus between the bridge (master) and the button block (slave).
interface btn_event_io_if;

    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/btn_event_io_debounce_cell.sv
// One button bit: two-flop synchronizer, debounce counter and stable level,
// with single-cycle pulses that coincide with the edge that updates stable.
module btn_debounce_cell #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_CNT_W  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [DEB_CNT_W-1:0] LAST_CNT = DEB_CNT_W'(DEB_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 stable_q;
    logic                 stable_d;
    logic [DEB_CNT_W-1:0] cnt_q;
    logic [DEB_CNT_W-1:0] cnt_d;

    // Any cycle where sync agrees with stable restarts the qualification run.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST_CNT) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;
    assign fall_o   = ~stable_d & stable_q;

endmodule

// File: rtl/btn_event_io.sv
// Button event peripheral: debounced levels, sticky W1C press/release flags,
// capture enable and a 16-bit press counter behind a simple register bus.
module btn_event_io
    import btn_event_io_pkg::*;
#(
    parameter int NBTN       = 5,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_CNT_W  = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] button_input,
    btn_event_io_if.slave   bus
);

    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] fall;

    for (genvar i = 0; i < NBTN; i++) begin : g_cell
        btn_debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES),
            .DEB_CNT_W  (DEB_CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_i    (button_input[i]),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    logic [NBTN-1:0] press_q;
    logic [NBTN-1:0] press_d;
    logic [NBTN-1:0] release_q;
    logic [NBTN-1:0] release_d;
    logic            ctrlEn_q;
    logic            ctrlEn_d;
    logic [15:0]     count_q;
    logic [15:0]     count_d;
    logic [15:0]     countInc;
    logic [2:0]      sel;
    logic [NBTN-1:0] clrMask;
    logic            unusedBits;

    assign sel        = bus.addr[4:2];
    assign clrMask    = bus.wdata[NBTN-1:0];
    assign unusedBits = ^{bus.addr[11:5], bus.addr[1:0], bus.wdata[31:NBTN]};
    assign countInc   = ctrlEn_q ? {11'b0, popCount16(16'(rise))} : 16'h0000;

    // Clear is applied before set so a same-cycle edge always survives a W1C.
    always_comb begin
        press_d   = press_q;
        release_d = release_q;
        ctrlEn_d  = ctrlEn_q;
        count_d   = count_q + countInc;
        if (bus.we && sel == REG_PRESS) begin
            press_d = press_q & ~clrMask;
        end
        if (bus.we && sel == REG_RELEASE) begin
            release_d = release_q & ~clrMask;
        end
        if (bus.we && sel == REG_CTRL) begin
            ctrlEn_d = bus.wdata[0];
        end
        if (bus.we && sel == REG_COUNT) begin
            count_d = countInc;
        end
        press_d   = press_d | (rise & {NBTN{ctrlEn_q}});
        release_d = release_d | (fall & {NBTN{ctrlEn_q}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q   <= '0;
            release_q <= '0;
            ctrlEn_q  <= 1'b1;
            count_q   <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            ctrlEn_q  <= ctrlEn_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (sel)
            REG_STATE:   bus.rdata = 32'(stable);
            REG_PRESS:   bus.rdata = 32'(press_q);
            REG_RELEASE: bus.rdata = 32'(release_q);
            REG_CTRL:    bus.rdata = {31'b0, ctrlEn_q};
            REG_COUNT:   bus.rdata = {16'b0, count_q};
            default:     bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_btn_event_io.sv
// Directed and randomized bench for btn_event_io; the reference model decides
// each debounced level from a window of past input samples.
module tb_btn_event_io;
    import btn_event_io_pkg::*;

    localparam int NBTN = 5;
    localparam int DEB  = 4;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rstN;
    logic [NBTN-1:0] btnIn;
    int              errors = 0;
    int              checks = 0;

    btn_event_io_if busIf ();

    btn_event_io #(
        .NBTN       (NBTN),
        .DEB_CYCLES (DEB),
        .DEB_CNT_W  (CNTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .button_input (btnIn),
        .bus          (busIf)
    );

    always #20 clk = ~clk;

    // hist[k] is the raw input that was present k clock edges ago.
    logic [NBTN-1:0] hist [1:DEB+1];
    logic [NBTN-1:0] mStable;
    logic [NBTN-1:0] mPress;
    logic [NBTN-1:0] mRelease;
    logic            mEn;
    logic [15:0]     mCount;

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a[4:2])
            3'd0:    return 32'(mStable);
            3'd1:    return 32'(mPress);
            3'd2:    return 32'(mRelease);
            3'd3:    return {31'b0, mEn};
            3'd4:    return {16'b0, mCount};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        for (int k = 1; k <= DEB + 1; k++) hist[k] = '0;
        mStable  = '0;
        mPress   = '0;
        mRelease = '0;
        mEn      = 1'b1;
        mCount   = 16'h0000;
    endtask

    // A level is accepted once the synchronized input has disagreed with it
    // for DEB consecutive cycles; sync lags the raw pin by two edges.
    task automatic modelEdge(input logic weV, input logic [11:0] a,
                             input logic [31:0] wd, input logic [NBTN-1:0] sample);
        logic [NBTN-1:0] newStable;
        logic [NBTN-1:0] rs;
        logic [NBTN-1:0] fl;
        logic            flip;
        int              riseCnt;
        newStable = mStable;
        for (int i = 0; i < NBTN; i++) begin
            flip = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) begin
                if (hist[j][i] == mStable[i]) flip = 1'b0;
            end
            if (flip) newStable[i] = ~mStable[i];
        end
        rs = newStable & ~mStable;
        fl = ~newStable & mStable;
        riseCnt = mEn ? $countones(rs) : 0;
        if (weV && a[4:2] == 3'd1) mPress = mPress & ~wd[NBTN-1:0];
        if (weV && a[4:2] == 3'd2) mRelease = mRelease & ~wd[NBTN-1:0];
        if (mEn) begin
            mPress   = mPress | rs;
            mRelease = mRelease | fl;
        end
        if (weV && a[4:2] == 3'd4) mCount = 16'(riseCnt);
        else mCount = mCount + 16'(riseCnt);
        if (weV && a[4:2] == 3'd3) mEn = wd[0];
        mStable = newStable;
        for (int j = DEB + 1; j >= 2; j--) hist[j] = hist[j-1];
        hist[1] = sample;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check the pre-write read, advance.
    task automatic applyStimulus(input logic [NBTN-1:0] b, input logic weV,
                                 input logic [11:0] a, input logic [31:0] wd);
        btnIn       = b;
        busIf.we    = weV;
        busIf.addr  = a;
        busIf.wdata = wd;
        #1;
        checkOutput("step_read", busIf.rdata, modelRead(a));
        @(posedge clk);
        if (rstN) modelEdge(weV, a, wd, b);
        else modelReset();
        @(negedge clk);
        busIf.we = 1'b0;
    endtask

    task automatic hold(input logic [NBTN-1:0] b, input int n);
        for (int k = 0; k < n; k++) applyStimulus(b, 1'b0, 12'(4 * (k % 6)), 32'h0);
    endtask

    task automatic checkAll(input string tag);
        busIf.we = 1'b0;
        for (int r = 0; r < 6; r++) begin
            busIf.addr = 12'(4 * r);
            #1;
            checkOutput(tag, busIf.rdata, modelRead(busIf.addr));
        end
    endtask

    task automatic expectReg(input string tag, input logic [11:0] a, input logic [31:0] v);
        busIf.we   = 1'b0;
        busIf.addr = a;
        #1;
        checkOutput(tag, busIf.rdata, v);
    endtask

    initial begin
        logic [NBTN-1:0] curBtn;
        logic [11:0]     ra;
        logic            rw;
        int              b;

        rstN        = 1'b0;
        btnIn       = '0;
        busIf.we    = 1'b0;
        busIf.addr  = '0;
        busIf.wdata = '0;
        modelReset();
        repeat (2) @(negedge clk);

        // Reset values
        checkAll("reset_all");
        expectReg("reset_ctrl", BTN_CTRL, 32'h1);
        expectReg("reset_state", BTN_STATE, 32'h0);
        expectReg("reset_0x14", 12'h014, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Clean press and release with exact latency
        hold(5'b00001, 5);
        expectReg("press_early", BTN_STATE, 32'h0);
        hold(5'b00001, 1);
        expectReg("press_state", BTN_STATE, 32'h1);
        expectReg("press_flag", BTN_PRESS, 32'h1);
        expectReg("press_count", BTN_COUNT, 32'h1);
        hold(5'b00000, 5);
        expectReg("release_early", BTN_STATE, 32'h1);
        hold(5'b00000, 1);
        expectReg("release_flag", BTN_RELEASE, 32'h1);
        expectReg("release_count", BTN_COUNT, 32'h1);
        expectReg("release_state", BTN_STATE, 32'h0);

        // Bounce rejection on bit2
        repeat (5) begin
            hold(5'b00100, 3);
            hold(5'b00000, 1);
        end
        expectReg("bounce_state", BTN_STATE, 32'h0);
        expectReg("bounce_press", BTN_PRESS, 32'h1);
        expectReg("bounce_count", BTN_COUNT, 32'h1);
        hold(5'b00100, 10);
        expectReg("settle_press", BTN_PRESS, 32'h5);
        expectReg("settle_count", BTN_COUNT, 32'h2);

        // W1C racing a new edge
        applyStimulus(5'b00100, 1'b1, BTN_PRESS, 32'h5);
        expectReg("w1c_clear", BTN_PRESS, 32'h0);
        hold(5'b00111, 6);
        expectReg("w1c_setup", BTN_PRESS, 32'h3);
        hold(5'b00110, 6);
        hold(5'b00111, 5);
        applyStimulus(5'b00111, 1'b1, BTN_PRESS, 32'h3);
        expectReg("w1c_setwins", BTN_PRESS, 32'h1);
        expectReg("w1c_count", BTN_COUNT, 32'h5);
        applyStimulus(5'b00111, 1'b1, BTN_PRESS, 32'h2);
        expectReg("w1c_noedge", BTN_PRESS, 32'h1);

        // Multi-press and counter wrap
        hold(5'b00100, 6);
        applyStimulus(5'b00100, 1'b1, BTN_PRESS, 32'h1F);
        applyStimulus(5'b00100, 1'b1, BTN_RELEASE, 32'h1F);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        mCount = 16'hFFFF;
        expectReg("wrap_preset", BTN_COUNT, 32'hFFFF);
        hold(5'b10111, 6);
        expectReg("wrap_count", BTN_COUNT, 32'h2);
        expectReg("wrap_press", BTN_PRESS, 32'h13);
        applyStimulus(5'b10111, 1'b1, BTN_COUNT, 32'hDEAD);
        expectReg("count_clear", BTN_COUNT, 32'h0);

        // Capture disabled, then reset in the middle of a debounce
        applyStimulus(5'b10111, 1'b1, BTN_CTRL, 32'h0);
        expectReg("ctrl_off", BTN_CTRL, 32'h0);
        hold(5'b11111, 6);
        expectReg("dis_state", BTN_STATE, 32'h1F);
        expectReg("dis_press", BTN_PRESS, 32'h13);
        expectReg("dis_count", BTN_COUNT, 32'h0);
        hold(5'b11101, 3);
        rstN = 1'b0;
        modelReset();
        checkAll("midreset_all");
        expectReg("midreset_ctrl", BTN_CTRL, 32'h1);
        hold(5'b11101, 3);
        rstN = 1'b1;
        hold(5'b11101, 5);
        expectReg("held_early", BTN_PRESS, 32'h0);
        hold(5'b11101, 1);
        expectReg("held_state", BTN_STATE, 32'h1D);
        expectReg("held_press", BTN_PRESS, 32'h1D);
        expectReg("held_count", BTN_COUNT, 32'h4);
        hold(5'b11101, 10);
        expectReg("no_late_press", BTN_PRESS, 32'h1D);
        expectReg("no_late_rel", BTN_RELEASE, 32'h0);
        expectReg("no_late_count", BTN_COUNT, 32'h4);

        // Randomized bouncing inputs and bus traffic against the model
        curBtn = 5'b11101;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = $urandom_range(0, NBTN - 1);
                curBtn[b] = ~curBtn[b];
            end
            rw = ($urandom_range(0, 5) == 0);
            ra = 12'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rstN = 1'b0;
                modelReset();
                applyStimulus(curBtn, 1'b0, ra, 32'h0);
                rstN = 1'b1;
            end
            applyStimulus(curBtn, rw, ra, $urandom);
        end
        checkAll("final_all");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_event_io.md
Name: btn_event_io

Overview:
- Bus responder peripheral on the bridge's peripheral port. Converts the 5 raw board buttons into debounced levels, sticky press/release event flags and a press counter.
- The CPU reads these through the bridge rdata path and clears them with writes.
- Replaces the plain level-read button block when software needs edge events without polling every cycle.

Parameters:
- NBTN, 5, number of button inputs (1..16).
- DEB_CYCLES, 500000, number of consecutive cycles a synchronized input must differ from the stable level before it is accepted (20 ms at 25 MHz; benches use 4).
- DEB_CNT_W, 20, debounce counter width; must satisfy 2^DEB_CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  cpu_clk from the bridge.
- rst_n  input  1  Asynchronous, active-low reset.
- addr  input  12  Byte offset within the peripheral window; bits [4:2] decode the register, other bits ignored.
- we  input  1  Write strobe, sampled on rising clk.
- wdata  input  32  Write data.
- button_input  input  NBTN  Raw, asynchronous button levels, high = pressed.
- rdata  output  32  Combinational read data for the current addr.

Behaviour:
- Register map (addr[4:2]):
  - 0 STATE (RO): [NBTN-1:0] debounced levels.
  - 1 PRESS (R/W1C): sticky rising-edge flags.
  - 2 RELEASE (R/W1C): sticky falling-edge flags.
  - 3 CTRL (RW): bit0 = capture enable; other bits read 0.
  - 4 COUNT (RO, write clears): [15:0] press counter.
  - 5-7: read 0, writes ignored. Unused high bits always read 0.
- Reset (rst_n low, async):
  - Synchronizers, stable levels, debounce counters, PRESS, RELEASE and COUNT go to 0.
  - CTRL.bit0 goes to 1.
  - rdata follows addr combinationally; it is 0 for every register except CTRL (value 1) while in reset.
- Synchronizer: 2 flops per bit. sync[i] lags button_input[i] by 2 clk.
- Debounce, per bit:
  - If sync == stable: counter is 0.
  - Otherwise the counter increments each cycle. On the cycle it equals DEB_CYCLES-1 (and sync still differs), stable <= sync and counter <= 0.
  - Any return of sync to the stable value clears the counter, so glitches shorter than DEB_CYCLES never change stable.
  - Total latency from a clean input step to a STATE change: 2 + DEB_CYCLES cycles.
- Edges: rise[i] = stable changes 0->1 this cycle; fall[i] = stable changes 1->0. Each is a single-cycle internal pulse.
- PRESS/RELEASE update:
  - flag <= (flag & ~clr) | (edge & en), where clr = wdata bits when we and the address selects that register.
  - When set and clear hit the same cycle, set wins.
  - en = CTRL.bit0. Clearing en stops new flags but does not clear existing ones.
- COUNT:
  - Each cycle with en=1 it adds the popcount of rise[]; wraps modulo 2^16.
  - A write to offset 4 (any wdata) loads COUNT with that cycle's increment (normally 0), i.e. clear wins but same-cycle presses are not lost.
- CTRL: a write loads bit0 from wdata[0].
- STATE tracks the input regardless of en.
- Reads have no side effects; read and write of the same register in the same cycle returns the pre-write value.
- Reset mid-debounce discards any pending transition.
- A button held at 1 through reset release produces exactly one PRESS event after 2 + DEB_CYCLES cycles.

Decomposition:
- Shared defines header holds:
  - Register offset constants: BTN_STATE 0x00, BTN_PRESS 0x04, BTN_RELEASE 0x08, BTN_CTRL 0x0C, BTN_COUNT 0x10.
  - The peripheral base-address constant the bridge decodes.
- One sub-module, btn_debounce_cell. It holds the 2-flop synchronizer, the counter and the stable flop for a single bit, and outputs stable/rise/fall. It is instantiated NBTN times via generate.
- Register file, popcount and read mux stay in the top.

Test Plan:
1. Reset values (DEB_CYCLES=4): hold rst_n low, read all offsets -> STATE=0, PRESS=0, RELEASE=0, CTRL=1, COUNT=0, offset 0x14=0.
2. Clean press: button_input=5'b00001 held -> STATE bit0 rises exactly 6 cycles later; PRESS=0x1, COUNT=1. Release it -> RELEASE=0x1 six cycles later, COUNT stays 1.
3. Bounce rejection: toggle bit2 high for 3 cycles, low for 1, repeated 5 times -> STATE, PRESS and COUNT unchanged. Then hold high 10 cycles -> exactly one PRESS bit2 and COUNT+1.
4. W1C with simultaneous set: with PRESS=0x3, write 0x3 to 0x04 in the same cycle bit0 rises again -> PRESS=0x1. A write of 0x2 with no edge -> PRESS=0x1 unchanged.
5. Multi-press and wrap: preset COUNT to 0xFFFF via 65535 presses (or force), then bits 0,1,4 rise in the same cycle -> COUNT=0x0002, PRESS=0x13. A write to 0x10 -> COUNT=0.
6. Enable and async reset: write CTRL=0, press bit3 -> STATE bit3=1, PRESS bit3=0, COUNT unchanged. Assert rst_n mid-debounce of bit1 -> all registers at reset values immediately, no late event after release.
